// File: rtl/sdram_arbiter.sv
// sdram_arbiter: fixed-priority (AREF > WRITE > READ) command arbiter that
// grants the SDRAM command/address pins to one sub-controller at a time,
// emits a one-cycle enable pulse to the granted engine, and recovers the bus
// through a per-grant watchdog if the engine never reports done.
module sdram_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int BA_BITS   = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                 sdram_clk,
  input  logic                 rst_n,
  input  logic                 init_done,
  input  logic [3:0]           init_cmd,
  input  logic [ADDR_BITS-1:0] init_addr,
  input  logic                 aref_req,
  input  logic                 aref_done,
  input  logic [3:0]           aref_cmd,
  input  logic [ADDR_BITS-1:0] aref_addr,
  input  logic                 wr_req,
  input  logic                 wr_done,
  input  logic [3:0]           wr_cmd,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [BA_BITS-1:0]   wr_ba,
  input  logic                 rd_req,
  input  logic                 rd_done,
  input  logic [3:0]           rd_cmd,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [BA_BITS-1:0]   rd_ba,
  output logic                 aref_en,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [3:0]           sdram_cmd,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [BA_BITS-1:0]   sdram_ba,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_AREF,
    S_WRITE,
    S_READ
  } state_e;

  state_e     state_q;
  logic       aref_en_q;
  logic       wr_en_q;
  logic       rd_en_q;
  logic       timeout_err_q;
  logic [7:0] wd_q;

  logic       grant_done;
  logic       wd_expired;

  // Done pulse of the engine currently holding the bus; others are ignored.
  always_comb begin
    grant_done = 1'b0;
    case (state_q)
      S_AREF:  grant_done = aref_done;
      S_WRITE: grant_done = wr_done;
      S_READ:  grant_done = rd_done;
      default: grant_done = 1'b0;
    endcase
  end

  assign wd_expired = (wd_q == WD_LAST);

  // Arbitration FSM with registered grant pulses, error pulse and watchdog.
  always_ff @(posedge sdram_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      aref_en_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          if (init_done) begin
            state_q <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (aref_req) begin
            state_q   <= S_AREF;
            aref_en_q <= 1'b1;
            wd_q      <= '0;
          end else if (wr_req) begin
            state_q <= S_WRITE;
            wr_en_q <= 1'b1;
            wd_q    <= '0;
          end else if (rd_req) begin
            state_q <= S_READ;
            rd_en_q <= 1'b1;
            wd_q    <= '0;
          end
        end
        S_AREF, S_WRITE, S_READ: begin
          // A done coinciding with expiry is a normal completion.
          if (grant_done) begin
            state_q <= S_IDLE;
          end else if (wd_expired) begin
            state_q       <= S_IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // Pin mux: zero-latency pass-through of the granted engine's outputs.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    case (state_q)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_ba;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a long
// randomized run compared cycle by cycle with a behavioural model.
module tb_sdram_arbiter;

  localparam int AB = 12;
  localparam int BB = 2;
  localparam int TO = 64;

  logic          sdram_clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic [3:0]    init_cmd;
  logic [AB-1:0] init_addr;
  logic          aref_req, aref_done;
  logic [3:0]    aref_cmd;
  logic [AB-1:0] aref_addr;
  logic          wr_req, wr_done;
  logic [3:0]    wr_cmd;
  logic [AB-1:0] wr_addr;
  logic [BB-1:0] wr_ba;
  logic          rd_req, rd_done;
  logic [3:0]    rd_cmd;
  logic [AB-1:0] rd_addr;
  logic [BB-1:0] rd_ba;
  logic          aref_en, wr_en, rd_en;
  logic [3:0]    sdram_cmd;
  logic [AB-1:0] sdram_addr;
  logic [BB-1:0] sdram_ba;
  logic          busy, timeout_err;

  int checks = 0;
  int errors = 0;

  sdram_arbiter #(.ADDR_BITS(AB), .BA_BITS(BB), .TIMEOUT(TO)) dut (
    .sdram_clk(sdram_clk), .rst_n(rst_n),
    .init_done(init_done), .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_req(aref_req), .aref_done(aref_done), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_done(wr_done), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .rd_req(rd_req), .rd_done(rd_done), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Behavioural model: who owns the bus and how long the current grant lasted.
  // owner: 0 = initialising, 1 = nobody, 2 = refresh, 3 = write, 4 = read
  int m_owner;
  int m_len;
  bit m_aen, m_wen, m_ren, m_terr;

  task automatic model_reset();
    m_owner = 0; m_len = 0;
    m_aen = 0; m_wen = 0; m_ren = 0; m_terr = 0;
  endtask

  task automatic model_edge();
    bit d;
    m_aen = 0; m_wen = 0; m_ren = 0; m_terr = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_owner == 0) begin
      if (init_done) m_owner = 1;
    end else if (m_owner == 1) begin
      if (aref_req)    begin m_owner = 2; m_aen = 1; m_len = 1; end
      else if (wr_req) begin m_owner = 3; m_wen = 1; m_len = 1; end
      else if (rd_req) begin m_owner = 4; m_ren = 1; m_len = 1; end
    end else begin
      d = (m_owner == 2) ? aref_done : (m_owner == 3) ? wr_done : rd_done;
      if (d) m_owner = 1;
      else if (m_len == TO) begin m_owner = 1; m_terr = 1; end
      else m_len++;
    end
  endtask

  function automatic logic [3+1+1+4+AB+BB-1:0] model_out();
    logic [3:0] c; logic [AB-1:0] a; logic [BB-1:0] b;
    c = 4'b0111; a = '0; b = '0;
    if (m_owner == 0) begin c = init_cmd; a = init_addr; end
    if (m_owner == 2) begin c = aref_cmd; a = aref_addr; end
    if (m_owner == 3) begin c = wr_cmd; a = wr_addr; b = wr_ba; end
    if (m_owner == 4) begin c = rd_cmd; a = rd_addr; b = rd_ba; end
    return {m_aen, m_wen, m_ren, (m_owner != 1), m_terr, c, a, b};
  endfunction

  task automatic tick();
    @(posedge sdram_clk);
    model_edge();
    #2;
  endtask

  task automatic idle_inputs();
    init_done = 0; aref_req = 0; wr_req = 0; rd_req = 0;
    aref_done = 0; wr_done = 0; rd_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    init_cmd = 4'b1010; init_addr = 12'h5A5;
    aref_cmd = 4'b0001; aref_addr = 12'h400;
    wr_cmd = 4'b0100; wr_addr = 12'h111; wr_ba = 2'd1;
    rd_cmd = 4'b0101; rd_addr = 12'h222; rd_ba = 2'd2;
    model_reset();
    #3;
    checks++;
    if ({aref_en, wr_en, rd_en, timeout_err, busy} !== 5'b00001) begin
      errors++; $display("FAIL reset_flags got %b want 00001", {aref_en, wr_en, rd_en, timeout_err, busy});
    end
    checks++;
    if ({sdram_cmd, sdram_addr, sdram_ba} !== {init_cmd, init_addr, 2'b00}) begin
      errors++; $display("FAIL reset_pins got %h/%h/%h want %h/%h/0", sdram_cmd, sdram_addr, sdram_ba, init_cmd, init_addr);
    end
    tick(); tick();
    rst_n = 1;
    aref_req = 1; wr_req = 1; rd_req = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if ({aref_en, wr_en, rd_en, busy} !== 4'b0001) begin
        errors++; $display("FAIL init_hold cyc %0d got %b want 0001", i, {aref_en, wr_en, rd_en, busy});
      end
    end
    idle_inputs(); init_done = 1;
    tick();
    init_done = 0; #1;
    checks++;
    if ({busy, sdram_cmd, sdram_addr, sdram_ba} !== {1'b0, 4'b0111, 12'h000, 2'b00}) begin
      errors++; $display("FAIL init_to_idle got busy=%b cmd=%b addr=%h want 0/0111/000", busy, sdram_cmd, sdram_addr);
    end
  endtask

  task automatic test_priority();
    aref_req = 1; wr_req = 1; rd_req = 1;
    tick();
    aref_req = 0; #1;
    checks++;
    if ({aref_en, wr_en, rd_en, sdram_cmd, sdram_addr} !== {3'b100, aref_cmd, aref_addr}) begin
      errors++; $display("FAIL prio_aref got en=%b cmd=%b want 100/%b", {aref_en, wr_en, rd_en}, sdram_cmd, aref_cmd);
    end
    tick();
    checks++;
    if ({aref_en, busy} !== 2'b01) begin
      errors++; $display("FAIL prio_aref_width got en=%b busy=%b want 0/1", aref_en, busy);
    end
    aref_done = 1; tick(); aref_done = 0; #1;
    checks++;
    if ({busy, wr_en, sdram_cmd} !== {2'b00, 4'b0111}) begin
      errors++; $display("FAIL prio_gap1 got busy=%b wr_en=%b cmd=%b want 0/0/0111", busy, wr_en, sdram_cmd);
    end
    tick(); wr_req = 0; #1;
    checks++;
    if ({aref_en, wr_en, rd_en, sdram_cmd} !== {3'b010, wr_cmd}) begin
      errors++; $display("FAIL prio_wr got en=%b cmd=%b want 010/%b", {aref_en, wr_en, rd_en}, sdram_cmd, wr_cmd);
    end
    wr_done = 1; tick(); wr_done = 0; #1;
    checks++;
    if ({busy, rd_en, sdram_cmd} !== {2'b00, 4'b0111}) begin
      errors++; $display("FAIL prio_gap2 got busy=%b rd_en=%b cmd=%b want 0/0/0111", busy, rd_en, sdram_cmd);
    end
    tick(); rd_req = 0; #1;
    checks++;
    if ({aref_en, wr_en, rd_en, sdram_cmd, sdram_ba} !== {3'b001, rd_cmd, rd_ba}) begin
      errors++; $display("FAIL prio_rd got en=%b cmd=%b want 001/%b", {aref_en, wr_en, rd_en}, sdram_cmd, rd_cmd);
    end
    rd_done = 1; tick(); rd_done = 0;
  endtask

  task automatic test_passthrough();
    wr_req = 1; wr_cmd = 4'b0100; wr_addr = 12'h123; wr_ba = 2'd3;
    tick(); wr_req = 0; #1;
    checks++;
    if ({sdram_cmd, sdram_addr, sdram_ba} !== {4'b0100, 12'h123, 2'd3}) begin
      errors++; $display("FAIL pass_wr got %b/%h/%0d want 0100/123/3", sdram_cmd, sdram_addr, sdram_ba);
    end
    wr_addr = 12'hABC; wr_cmd = 4'b0010; #1;
    checks++;
    if ({sdram_cmd, sdram_addr} !== {4'b0010, 12'hABC}) begin
      errors++; $display("FAIL pass_same_cycle got %b/%h want 0010/abc", sdram_cmd, sdram_addr);
    end
    wr_done = 1; tick(); wr_done = 0; #1;
    checks++;
    if ({busy, sdram_cmd} !== {1'b0, 4'b0111}) begin
      errors++; $display("FAIL pass_release got busy=%b cmd=%b want 0/0111", busy, sdram_cmd);
    end
  endtask

  task automatic test_no_preempt();
    rd_req = 1; tick(); rd_req = 0;
    tick(); aref_req = 1; wr_req = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({aref_en, busy, sdram_cmd} !== {2'b01, rd_cmd}) begin
        errors++; $display("FAIL nopre_hold cyc %0d got aref_en=%b busy=%b cmd=%b", i, aref_en, busy, sdram_cmd);
      end
    end
    rd_done = 1; tick(); rd_done = 0; #1;
    checks++;
    if ({aref_en, busy} !== 2'b00) begin
      errors++; $display("FAIL nopre_gap got aref_en=%b busy=%b want 0/0", aref_en, busy);
    end
    tick(); aref_req = 0; #1;
    checks++;
    if ({aref_en, wr_en} !== 2'b10) begin
      errors++; $display("FAIL nopre_aref got aref_en=%b wr_en=%b want 1/0", aref_en, wr_en);
    end
    aref_done = 1; tick(); aref_done = 0;
    tick(); wr_req = 0; #1;
    checks++;
    if (wr_en !== 1'b1) begin
      errors++; $display("FAIL nopre_wr_after got wr_en=%b want 1", wr_en);
    end
    wr_done = 1; tick(); wr_done = 0;
  endtask

  task automatic test_timeout();
    int n;
    int terr_seen;
    rd_req = 1; tick(); rd_req = 0;
    n = 0; terr_seen = 0;
    while (busy && n < 200) begin
      n++;
      aref_done = (n == 10); wr_done = (n == 20);
      if (timeout_err) terr_seen++;
      tick();
    end
    aref_done = 0; wr_done = 0;
    checks++;
    if (n !== TO) begin
      errors++; $display("FAIL timeout_len got %0d read cycles want %0d", n, TO);
    end
    checks++;
    if ({timeout_err, busy, terr_seen[0]} !== 3'b100) begin
      errors++; $display("FAIL timeout_pulse got err=%b busy=%b early=%0d want 1/0/0", timeout_err, busy, terr_seen);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_width got %b want 0", timeout_err);
    end
    // Done together with expiry completes normally.
    rd_req = 1; tick(); rd_req = 0;
    for (int i = 1; i < TO; i++) tick();
    rd_done = 1; tick(); rd_done = 0; #1;
    checks++;
    if ({timeout_err, busy} !== 2'b00) begin
      errors++; $display("FAIL timeout_done_race got err=%b busy=%b want 0/0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    wr_req = 1; tick(); #1;
    checks++;
    if (wr_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_grant got wr_en=%b want 1", wr_en);
    end
    rst_n = 0; model_reset(); #1;
    checks++;
    if ({wr_en, busy, sdram_cmd} !== {2'b01, init_cmd}) begin
      errors++; $display("FAIL rstmid_async got wr_en=%b busy=%b cmd=%b want 0/1/%b", wr_en, busy, sdram_cmd, init_cmd);
    end
    aref_req = 1; rd_req = 1;
    tick(); tick(); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({aref_en, wr_en, rd_en, busy, sdram_cmd} !== {4'b0001, init_cmd}) begin
        errors++; $display("FAIL rstmid_init cyc %0d got %b/%b", i, {aref_en, wr_en, rd_en, busy}, sdram_cmd);
      end
    end
    init_done = 1; tick(); init_done = 0;
    tick(); idle_inputs(); #1;
    checks++;
    if (aref_en !== 1'b1) begin
      errors++; $display("FAIL rstmid_recover got aref_en=%b want 1", aref_en);
    end
    aref_done = 1; tick(); aref_done = 0;
  endtask

  task automatic test_random();
    bit hang;
    int prev_owner;
    hang = 0; prev_owner = m_owner;
    for (int i = 0; i < 3000; i++) begin
      if (m_owner != prev_owner && m_owner >= 2) hang = ($urandom_range(0, 9) == 0);
      prev_owner = m_owner;
      init_done = ($urandom_range(0, 3) == 0);
      aref_req  = ($urandom_range(0, 5) == 0);
      wr_req    = ($urandom_range(0, 2) == 0);
      rd_req    = ($urandom_range(0, 2) == 0);
      aref_done = ($urandom_range(0, 4) == 0) && !(hang && m_owner == 2);
      wr_done   = ($urandom_range(0, 4) == 0) && !(hang && m_owner == 3);
      rd_done   = ($urandom_range(0, 4) == 0) && !(hang && m_owner == 4);
      init_cmd = 4'($urandom); init_addr = AB'($urandom);
      aref_cmd = 4'($urandom); aref_addr = AB'($urandom);
      wr_cmd = 4'($urandom); wr_addr = AB'($urandom); wr_ba = BB'($urandom);
      rd_cmd = 4'($urandom); rd_addr = AB'($urandom); rd_ba = BB'($urandom);
      if (i % 1000 == 999) begin rst_n = 0; model_reset(); end
      if (i % 1000 == 2) rst_n = 1;
      #1;
      checks++;
      if ({aref_en, wr_en, rd_en, busy, timeout_err, sdram_cmd, sdram_addr, sdram_ba} !== model_out()) begin
        errors++;
        $display("FAIL random cyc %0d got %h want %h", i,
                 {aref_en, wr_en, rd_en, busy, timeout_err, sdram_cmd, sdram_addr, sdram_ba}, model_out());
      end
      tick();
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_passthrough();
    test_no_preempt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
